// File: rtl/i2s_frame_clkgen_pkg.sv
// Shared I2S timing definitions: FSM state encoding and default frame/half-period
// constants reused by the clock generator and the serializer/deserializer blocks.
package i2s_frame_clkgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_HP_W       = 8;
    localparam int DEF_FRAME_BITS = 64;
    localparam int DEF_HALF_PER   = 3;

endpackage

// File: rtl/i2s_half_timer.sv
// Loadable down-counter for the BCLK half-period; o_tc marks the last clk of a half.
module i2s_half_timer
    import i2s_frame_clkgen_pkg::*;
#(
    parameter int HP_W = DEF_HP_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_en,
    input  logic            i_load,
    input  logic [HP_W-1:0] i_load_val,
    input  logic [HP_W-1:0] i_reload_val,
    output logic            o_tc
);

    localparam logic [HP_W-1:0] HP_ONE = HP_W'(1);

    logic [HP_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? i_reload_val : r_cnt - HP_ONE;
        end
    end

    assign o_tc = i_en && (r_cnt == '0);

endmodule

// File: rtl/i2s_frame_clkgen.sv
// I2S master timing generator: BCLK, LRCLK, per-bit strobes and frame-rate strobe,
// with runtime half-period (applied at frame boundaries) and drain-to-frame-end stop.
module i2s_frame_clkgen
    import i2s_frame_clkgen_pkg::*;
#(
    parameter int HP_W       = DEF_HP_W,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int BIT_W      = $clog2(FRAME_BITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [HP_W-1:0]  half_per,
    output logic             rate,
    output logic             bclk,
    output logic             lrclk,
    output logic             bit_strb,
    output logic             rise_strb,
    output logic [BIT_W-1:0] bit_idx,
    output logic             running
);

    localparam logic [HP_W-1:0]  HP_ONE   = HP_W'(1);
    localparam logic [BIT_W-1:0] IDX_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] IDX_LAST = BIT_W'(FRAME_BITS - 1);

    state_t           r_state;
    logic [HP_W-1:0]  r_hp_act;
    logic             r_bclk;
    logic             r_rate;
    logic             r_bit_strb;
    logic             r_rise_strb;
    logic [BIT_W-1:0] r_bit_idx;

    logic [HP_W-1:0]  w_hp_new;
    logic             w_tc;
    logic             w_rise;
    logic             w_fall;
    logic             w_wrap;
    logic             w_load;
    logic [HP_W-1:0]  w_load_val;
    logic             w_cnt_en;

    assign w_hp_new = (half_per == '0) ? HP_ONE : half_per;
    assign w_cnt_en = (r_state != ST_IDLE);
    assign w_rise   = w_tc && !r_bclk;
    assign w_fall   = w_tc && r_bclk;
    assign w_wrap   = w_fall && (r_bit_idx == IDX_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (r_state == ST_IDLE) begin
            if (enable) begin
                w_load     = 1'b1;
                w_load_val = w_hp_new - HP_ONE;
            end
        end else if (w_wrap) begin
            // A drain that ends here parks the counter at zero for the next start.
            w_load     = 1'b1;
            w_load_val = (r_state == ST_DRAIN) ? '0 : w_hp_new - HP_ONE;
        end
    end

    i2s_half_timer #(.HP_W(HP_W)) u_half_timer (
        .clk          (clk),
        .reset        (reset),
        .i_en         (w_cnt_en),
        .i_load       (w_load),
        .i_load_val   (w_load_val),
        .i_reload_val (r_hp_act - HP_ONE),
        .o_tc         (w_tc)
    );

    // NOTE: reset is synchronous and overrides everything, including a pending drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_hp_act    <= HP_ONE;
            r_bclk      <= 1'b0;
            r_rate      <= 1'b0;
            r_bit_strb  <= 1'b0;
            r_rise_strb <= 1'b0;
            r_bit_idx   <= '0;
        end else begin
            r_rate      <= 1'b0;
            r_bit_strb  <= 1'b0;
            r_rise_strb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state    <= ST_RUN;
                        r_hp_act   <= w_hp_new;
                        r_bclk     <= 1'b0;
                        r_bit_idx  <= '0;
                        r_rate     <= 1'b1;
                        r_bit_strb <= 1'b1;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (r_state == ST_RUN && !enable) r_state <= ST_DRAIN;
                    if (r_state == ST_DRAIN && enable) r_state <= ST_RUN;
                    if (w_rise) begin
                        r_bclk      <= 1'b1;
                        r_rise_strb <= 1'b1;
                    end
                    if (w_fall) begin
                        r_bclk <= 1'b0;
                        if (!w_wrap) begin
                            r_bit_idx  <= r_bit_idx + IDX_ONE;
                            r_bit_strb <= 1'b1;
                        end else if (r_state == ST_DRAIN) begin
                            // Frame boundary while draining: stop silently, no pulses.
                            r_state   <= ST_IDLE;
                            r_bit_idx <= '0;
                        end else begin
                            r_bit_idx  <= '0;
                            r_bit_strb <= 1'b1;
                            r_rate     <= 1'b1;
                            r_hp_act   <= w_hp_new;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rate      = r_rate;
    assign bclk      = r_bclk;
    assign bit_strb  = r_bit_strb;
    assign rise_strb = r_rise_strb;
    assign bit_idx   = r_bit_idx;
    assign lrclk     = r_bit_idx[BIT_W-1];
    assign running   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i2s_frame_clkgen.sv
// Directed bench for i2s_frame_clkgen: default 64-bit frame plus a 32-bit frame instance.
module tb_i2s_frame_clkgen;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [7:0] half_per;
    logic       rate, bclk, lrclk, bit_strb, rise_strb, running;
    logic [5:0] bit_idx;

    logic       reset2, enable2;
    logic [7:0] half_per2;
    logic       rate2, bclk2, lrclk2, bit_strb2, rise_strb2, running2;
    logic [4:0] bit_idx2;

    int checks = 0;
    int errors = 0;
    int c, nb, nr, lh, nbo, nn, n1, n2, nrate;

    always #5 clk = ~clk;

    i2s_frame_clkgen dut (
        .clk(clk), .reset(reset), .enable(enable), .half_per(half_per),
        .rate(rate), .bclk(bclk), .lrclk(lrclk), .bit_strb(bit_strb),
        .rise_strb(rise_strb), .bit_idx(bit_idx), .running(running)
    );

    i2s_frame_clkgen #(.FRAME_BITS(32)) dut2 (
        .clk(clk), .reset(reset2), .enable(enable2), .half_per(half_per2),
        .rate(rate2), .bclk(bclk2), .lrclk(lrclk2), .bit_strb(bit_strb2),
        .rise_strb(rise_strb2), .bit_idx(bit_idx2), .running(running2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Tick until the next rate pulse (inclusive), tallying strobes and lrclk-high cycles.
    task automatic next_rate(input int limit, output int cyc, output int nbits, output int nrise,
                             output int lrhi, output int nboth, output int nnone);
        cyc = 0; nbits = 0; nrise = 0; lrhi = 0; nboth = 0; nnone = 0;
        do begin
            tick();
            cyc++;
            if (bit_strb) nbits++;
            if (rise_strb) nrise++;
            if (lrclk) lrhi++;
            if (bit_strb && rise_strb) nboth++;
            if (!bit_strb && !rise_strb) nnone++;
        end while (!rate && cyc < limit);
    endtask

    task automatic until_idx(input logic [5:0] target, input int limit, output int cyc);
        cyc = 0;
        while (bit_idx != target && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; half_per = 8'd3;
        reset2 = 1'b1; enable2 = 1'b0; half_per2 = 8'd4;
        repeat (3) tick();
        check("reset_outputs", {rate, bclk, lrclk, bit_strb, rise_strb, running, bit_idx}, 32'd0);

        // Start from reset with enable high: rate and bit_strb in the first cycle.
        reset = 1'b0; enable = 1'b1;
        tick();
        check("start_vector", {rate, bclk, lrclk, bit_strb, rise_strb, running, bit_idx}, {6'b100101, 6'd0});

        n1 = 0;
        while (!bclk && n1 < 100) begin n1++; tick(); end
        check("bclk_low_len", n1, 3);
        check("rise_strobe", {rise_strb, bit_strb}, 2'b10);
        n1 = 0;
        while (bclk && n1 < 100) begin n1++; tick(); end
        check("bclk_high_len", n1, 3);
        check("fall_strobe_idx", {rise_strb, bit_strb, bit_idx}, {1'b0, 1'b1, 6'd1});

        next_rate(1000, c, nb, nr, lh, nbo, nn);
        check("first_frame_rest", c, 378);

        next_rate(1000, c, nb, nr, lh, nbo, nn);
        check("frame384_period", c, 384);
        check("frame384_bits", nb, 64);
        check("frame384_rises", nr, 64);
        check("frame384_lrhi", lh, 192);

        // Half-period change mid-frame only takes effect at the next boundary.
        until_idx(6'd10, 1000, n1);
        half_per = 8'd2;
        next_rate(1000, c, nb, nr, lh, nbo, nn);
        check("hp_change_cur_frame", n1 + c, 384);
        next_rate(1000, c, nb, nr, lh, nbo, nn);
        check("hp2_period", c, 256);
        check("hp2_bits", nb, 64);

        // half_per = 0 behaves as 1.
        half_per = 8'd0;
        next_rate(1000, c, nb, nr, lh, nbo, nn);
        check("hp0_cur_frame", c, 256);
        next_rate(1000, c, nb, nr, lh, nbo, nn);
        check("hp1_period", c, 128);
        check("hp1_bits", nb, 64);
        check("hp1_rises", nr, 64);
        check("hp1_coincident", nbo, 0);
        check("hp1_gaps", nn, 0);

        // Drain: drop enable at bit 5, frame completes, IDLE without a rate pulse.
        half_per = 8'd3;
        next_rate(1000, c, nb, nr, lh, nbo, nn);
        check("hp1_last_frame", c, 128);
        until_idx(6'd5, 1000, n1);
        check("drain_idx5_offset", n1, 30);
        enable = 1'b0;
        c = 0; nrate = 0;
        while (running && c < 1000) begin
            tick();
            c++;
            if (rate) nrate++;
        end
        check("drain_len", c, 354);
        check("drain_no_rate", nrate, 0);
        check("drain_idle_outputs", {rate, bclk, lrclk, bit_strb, rise_strb, running, bit_idx}, 32'd0);

        // Restart, then drop and re-raise enable inside the drain: no stop.
        enable = 1'b1;
        tick();
        check("restart_vector", {rate, bit_strb, running, bit_idx}, {3'b111, 6'd0});
        until_idx(6'd5, 1000, n1);
        enable = 1'b0;
        until_idx(6'd40, 1000, n2);
        check("redrain_running", running, 1);
        enable = 1'b1;
        next_rate(1000, c, nb, nr, lh, nbo, nn);
        check("reenable_period", n1 + n2 + c, 384);

        // Reset mid-frame at bit 20 with bclk high aborts immediately.
        until_idx(6'd20, 1000, n1);
        n2 = 0;
        while (!bclk && n2 < 100) begin n2++; tick(); end
        check("pre_reset_state", {bclk, bit_idx}, {1'b1, 6'd20});
        reset = 1'b1;
        tick();
        check("midframe_reset", {rate, bclk, lrclk, bit_strb, rise_strb, running, bit_idx}, 32'd0);
        reset = 1'b0;
        tick();
        check("post_reset_start", {rate, bit_strb, running, bclk, bit_idx}, {4'b1110, 6'd0});
        next_rate(1000, c, nb, nr, lh, nbo, nn);
        check("post_reset_period", c, 384);

        // FRAME_BITS = 32, half_per = 4.
        reset2 = 1'b0; enable2 = 1'b1;
        tick();
        check("fb32_start", {rate2, bit_strb2, bit_idx2}, {2'b11, 5'd0});
        c = 0; nb = 0; lh = 0; n1 = 0; n2 = 0;
        begin
            logic [4:0] prev_idx;
            prev_idx = bit_idx2;
            do begin
                tick();
                c++;
                if (lrclk2) lh++;
                if (bit_idx2 == 5'd15 && lrclk2) nb++;
                if (bit_idx2 == 5'd16 && !lrclk2) nb++;
                if (bit_idx2 == 5'd16) n1++;
                if (rate2 && bit_idx2 == 5'd0 && prev_idx == 5'd31) n2 = 1;
                prev_idx = bit_idx2;
            end while (!rate2 && c < 1000);
        end
        check("fb32_period", c, 256);
        check("fb32_lrclk_edge", nb, 0);
        check("fb32_idx16_len", n1, 8);
        check("fb32_lrhi", lh, 128);
        check("fb32_wrap_rate", n2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_frame_clkgen.md
Name: i2s_frame_clkgen

Overview:
- Parametrised successor to the fixed /384 sample-rate strobe generator.
- Derives a complete I2S master timing set from one system clock:
  - per-frame sample-rate strobe
  - bit clock (BCLK) and word-select (LRCLK)
  - per-bit strobes and the current bit index
- Bit-clock half-period is selectable at runtime and is applied only at frame boundaries.
- Has a start/drain-stop handshake, so serializers and deserializers never see a truncated frame.

Parameters:
- HP_W, 8, width of the half_per input.
- FRAME_BITS, 64, BCLK cycles per frame (L+R). Must be a power of two, >= 4.
- BIT_W, $clog2(FRAME_BITS), width of bit_idx (derived; do not override).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; high requests running, low requests stop at the next frame end
- half_per  in  HP_W  BCLK half-period in clk cycles; 0 is treated as 1
- rate  out  1  one-cycle strobe at the start of each frame
- bclk  out  1  bit clock, registered
- lrclk  out  1  word select: 0 = left (bits 0..FRAME_BITS/2-1), 1 = right
- bit_strb  out  1  one-cycle strobe when bclk falls (new bit starts)
- rise_strb  out  1  one-cycle strobe when bclk rises
- bit_idx  out  BIT_W  index of the current bit within the frame
- running  out  1  high in RUN or DRAIN

Behaviour:
- Timing relations:
  - Frame period = 2*FRAME_BITS*hp_act clk cycles.
  - Defaults (hp=3, FRAME_BITS=64) give 384 cycles, i.e. 41.7 kHz at 16 MHz.
  - hp_act is an internal latched copy of max(half_per,1).
- Reset (synchronous, highest priority, any state):
  - Next edge: state=IDLE.
  - All outputs 0, including rate, bclk, lrclk, both strobes, bit_idx and running.
  - hcnt=0, hp_act=1.
- States are IDLE, RUN and DRAIN.
  - IDLE:
    - Outputs held at 0.
    - enable=1 -> RUN at the next edge. On that edge:
      - hp_act <= max(half_per,1) and hcnt <= hp_act-1.
      - bclk=0, bit_idx=0.
      - rate=1 and bit_strb=1 for that first cycle.
  - RUN:
    - hcnt decrements each cycle.
    - When hcnt==0: hcnt reloads to hp_act-1 and bclk toggles.
    - bclk 0->1: rise_strb=1 in the same cycle the new bclk level is visible.
    - bclk 1->0:
      - bit_idx increments (wraps FRAME_BITS-1 -> 0); bit_strb=1 in the same cycle.
      - On wrap to 0 (frame boundary), rate=1 and hp_act reloads from the current half_per. The new half-period applies from this cycle's hcnt reload.
    - enable=0 -> DRAIN at the next edge. Counting continues uninterrupted.
  - DRAIN:
    - Counts identically to RUN.
    - At the edge that would produce the frame boundary, go to IDLE instead: all outputs 0, with no rate or bit_strb pulse.
    - enable=1 seen before that edge -> back to RUN with no discontinuity.
- lrclk is combinationally equal to bit_idx[BIT_W-1], driven from registered bit_idx. It is 0 in IDLE.
- All strobes are exactly one cycle wide.
- Boundary cases:
  - With hp_act=1, bclk toggles every cycle. rise_strb and bit_strb then alternate every cycle, never coincident.
  - A half_per change mid-frame has no effect until the next boundary.
  - A reset mid-frame aborts immediately; no drain.
  - enable toggling within one cycle of the boundary: the sampled enable at the boundary edge decides. State DRAIN at that edge -> IDLE; RUN -> continue.

Decomposition:
- Shared package/include holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2
  - the default FRAME_BITS and half-period constants, for reuse by i2s_tx/i2s_rx
- One natural sub-module, i2s_half_timer:
  - loadable down-counter producing a terminal-count pulse and reload
  - parameter HP_W
- Remaining FSM, bclk, bit_idx and strobe logic stay in the top.

Test Plan:
- Default params, half_per=3, enable held 1 -> rate pulses spaced exactly 384 cycles; bclk 3 low/3 high; lrclk high for bit_idx 32..63; 64 bit_strb per frame.
- Change half_per 3->2 at bit_idx=10 -> current frame still 384 cycles; following frame periods 256.
- half_per=0 -> treated as 1: bclk toggles every cycle, rate period 128, rise_strb/bit_strb alternate.
- Drop enable at bit_idx=5 -> frame completes to bit 63; IDLE entered at the 384th cycle from last rate with no rate pulse; running=0. Re-raising enable in DRAIN at bit_idx=40 -> no stop, next rate at normal spacing.
- Assert reset at bit_idx=20, bclk=1 -> next edge all outputs 0, state IDLE. Release with enable=1 -> rate and bit_strb in the first cycle after reset deasserts, then normal 384 spacing.
- FRAME_BITS=32, half_per=4 -> rate period 256; lrclk toggles at bit_idx 16; bit_idx wraps 31->0 coincident with rate.
